// File: rtl/reg_file_clr.sv
// 2-read/1-write register file with synchronous reset, one-entry-per-clock soft-clear sweep
// and Busy flag. Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_clr #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Clr,
  input  logic              Wren,
  input  logic [ADDR_W-1:0] Regw,
  input  logic [DATA_W-1:0] wBus,
  input  logic [ADDR_W-1:0] Regs,
  input  logic [ADDR_W-1:0] Regt,
  output logic [DATA_W-1:0] outputReg1,
  output logic [DATA_W-1:0] outputReg2,
  output logic              Busy
);

  localparam int unsigned       DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CntLast = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              wr_ok;

  assign busy = (state_q == StClear);
  assign Busy = busy;

  // A host write lands only in IDLE, with no reset/clear, and never on a hardwired r0.
  assign wr_ok = (state_q == StIdle) && Wren && !Rst && !Clr &&
                 !((ZERO_REG != 0) && (Regw == '0));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = Regw;
    mem_wdata = wBus;
    unique case (state_q)
      StIdle: begin
        if (Clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (wr_ok) begin
          mem_we = 1'b1;
        end
      end
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (Clr) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Reset only restarts the sweep; it never touches storage itself.
    if (Rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage has no reset so it can map onto RAM; the sweep zeroes it instead.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    outputReg1 = mem_q[Regs];
    outputReg2 = mem_q[Regt];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (Regs == Regw)) begin
      outputReg1 = wBus;
    end
    if (wr_ok && (Regt == Regw)) begin
      outputReg2 = wBus;
    end
`endif
    if (busy || ((ZERO_REG != 0) && (Regs == '0))) begin
      outputReg1 = '0;
    end
    if (busy || ((ZERO_REG != 0) && (Regt == '0))) begin
      outputReg2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_clr.sv
// Directed bench for reg_file_clr: reset sweep, table-driven read/write vectors, clear and
// restart timing, and a ZERO_REG=0 instance sharing the same stimulus.
module tb_reg_file_clr;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst, Clr, Wren;
  logic [4:0]  Regw, Regs, Regt;
  logic [31:0] wBus;
  logic [31:0] o1, o2, n1, n2;
  logic        busy, nbusy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wren;
    logic [4:0]  regw;
    logic [31:0] wdata;
    logic [4:0]  regs;
    logic [4:0]  regt;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [9];

  always #5 Clk = ~Clk;

  reg_file_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .Wren(Wren), .Regw(Regw), .wBus(wBus),
    .Regs(Regs), .Regt(Regt), .outputReg1(o1), .outputReg2(o2), .Busy(busy)
  );

  reg_file_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_nz (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .Wren(Wren), .Regw(Regw), .wBus(wBus),
    .Regs(Regs), .Regt(Regt), .outputReg1(n1), .outputReg2(n2), .Busy(nbusy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at the first negedge after the sweep-starting edge; counts Busy cycles.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
  endtask

  task automatic check_all_zero(input string nm);
    for (int i = 0; i < 32; i++) begin
      Regs = 5'(i);
      Regt = 5'(31 - i);
      #1;
      chk(nm, o1, 32'h0);
      chk(nm, o2, 32'h0);
    end
  endtask

  // Start a sweep from IDLE, then hit Clr or Rst during sweep cycle 10.
  task automatic sweep_restart(input bit use_rst, output int n);
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (use_rst) Rst = (n == 10);
      else         Clr = (n == 10);
      @(negedge Clk);
      n++;
    end
    Rst = 1'b0;
    Clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd5,  5'd7,  32'hDEADBEEF,
                Byp ? 32'hA5A5A5A5 : 32'h0};
    vecs[4] = '{1'b0, 5'd7,  32'h0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[5] = '{1'b0, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,  32'h0, 32'h0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'h0, 32'hA5A5A5A5};
    vecs[7] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd31,
                Byp ? 32'h12345678 : 32'h0, Byp ? 32'h12345678 : 32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'h12345678, 32'hA5A5A5A5};

    // Reset, with a write attempt held throughout the sweep.
    Rst = 1'b1; Clr = 1'b0; Wren = 1'b1; Regw = 5'd5; wBus = 32'h00000BAD;
    Regs = 5'd31; Regt = 5'd5;
    @(negedge Clk);
    Rst = 1'b0;
    chk("busy_after_rst", 32'(busy), 32'h1);
    chk("rd1_forced_busy", o1, 32'h0);
    chk("rd2_forced_busy", o2, 32'h0);
    count_busy(n);
    Wren = 1'b0;
    chk("rst_busy_cycles", 32'(n), 32'd32);
    chk("busy_low_after_rst_sweep", 32'(busy), 32'h0);
    check_all_zero("zero_after_rst");

    // Table-driven IDLE read/write vectors.
    @(negedge Clk);
    for (int i = 0; i < 9; i++) begin
      Wren = vecs[i].wren; Regw = vecs[i].regw; wBus = vecs[i].wdata;
      Regs = vecs[i].regs; Regt = vecs[i].regt;
      #2;
      chk($sformatf("vec%0d_rd1", i), o1, vecs[i].exp1);
      chk($sformatf("vec%0d_rd2", i), o2, vecs[i].exp2);
      @(negedge Clk);
    end
    Wren = 1'b0;

    // Fill r1..r31 with their index, then soft-clear with a colliding write.
    for (int i = 1; i < 32; i++) begin
      Wren = 1'b1; Regw = 5'(i); wBus = 32'(i);
      @(negedge Clk);
    end
    Wren = 1'b0;
    Regs = 5'd3; Regt = 5'd31;
    #1;
    chk("fill_r3", o1, 32'd3);
    chk("fill_r31", o2, 32'd31);
    Clr = 1'b1; Wren = 1'b1; Regw = 5'd3; wBus = 32'hFF; Regs = 5'd4; Regt = 5'd30;
    @(negedge Clk);
    Clr = 1'b0; Wren = 1'b0;
    chk("busy_after_clr", 32'(busy), 32'h1);
    count_busy(n);
    chk("clr_busy_cycles", 32'(n), 32'd32);
    check_all_zero("zero_after_clr");

    // Restart the sweep at cycle 10, by Clr and then by Rst.
    @(negedge Clk);
    sweep_restart(1'b0, n);
    chk("clr_restart_cycles", 32'(n), 32'd43);
    @(negedge Clk);
    sweep_restart(1'b1, n);
    chk("rst_restart_cycles", 32'(n), 32'd43);

    // r0 is ordinary in the ZERO_REG=0 instance.
    @(negedge Clk);
    Wren = 1'b1; Regw = 5'd0; wBus = 32'h55; Regs = 5'd0; Regt = 5'd0;
    #2;
    chk("nz_r0_same_cycle", n1, Byp ? 32'h55 : 32'h0);
    chk("z_r0_same_cycle", o1, 32'h0);
    @(negedge Clk);
    Wren = 1'b0;
    #1;
    chk("nz_r0_written", n1, 32'h55);
    chk("nz_r0_port2", n2, 32'h55);
    chk("z_r0_dropped", o1, 32'h0);
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    chk("nz_busy_after_clr", 32'(nbusy), 32'h1);
    count_busy(n);
    chk("nz_clr_busy_cycles", 32'(n), 32'd32);
    #1;
    chk("nz_r0_cleared", n1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
